// File: rtl/shift_seq_pkg.sv
// Shared types for the multi-word right-shift sequencer: controller states and
// shift modes as carried on the block's op lines.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    EXEC  = 2'b10,
    DRAIN = 2'b11
  } state_t;

  // The reserved code behaves as a logical shift.
  typedef enum logic [1:0] {
    MODE_LOGICAL = 2'b00,
    MODE_ARITH   = 2'b01,
    MODE_ROTATE  = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_t;

endpackage

// File: rtl/right_shift_sequencer_if.sv
// Operand-in / result-out word streams of the right-shift sequencer.
interface right_shift_sequencer_if #(
  parameter int W = 8
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport slave (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/shift_fill_select.sv
// Chooses the W-1 fill bits that enter the word at idx from above: the unshifted
// upper neighbour, or for the top word a mode-dependent fill.
module shift_fill_select
  import shift_seq_pkg::*;
#(
  parameter int W = 8,
  parameter int WORDS = 4,
  localparam int IW = $clog2(WORDS)
) (
  input  mode_t                   mode,
  input  logic [WORDS-1:0][W-1:0] words,
  input  logic [W-2:0]            lowsave,
  input  logic [IW-1:0]           idx,
  output logic [W-2:0]            fill
);

  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  logic         is_top;
  logic [W-1:0] sel_word;

  // Top word: rotate wraps in the saved low bits of word 0, arithmetic replicates the sign.
  always_comb begin
    is_top   = (idx == LAST);
    sel_word = is_top ? words[WORDS-1] : words[idx + 1'b1];
    fill     = sel_word[W-2:0];
    if (is_top) begin
      case (mode)
        MODE_ARITH:  fill = {(W-1){sel_word[W-1]}};
        MODE_ROTATE: fill = lowsave;
        default:     fill = '0;
      endcase
    end
  end

endmodule

// File: rtl/right_shift_sequencer.sv
// Multi-word right-shift controller: loads an operand LSW first, runs the shared
// right_shift_block once per word, then streams the result out LSW first.
module right_shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int WORDS = 4,
  localparam int AW = $clog2(WORD_WIDTH),
  localparam int IW = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic [AW-1:0]         amt_i,
  output logic                  busy_o,
  right_shift_sequencer_if.master stream,
  input  logic                  cf_i,
  output logic [1:0]            sh_op_o,
  output logic [WORD_WIDTH-1:0] sh_a_o,
  output logic [WORD_WIDTH-1:0] sh_b_o,
  output logic [WORD_WIDTH-2:0] sh_c_o,
  output logic                  sh_cf_o,
  input  logic [WORD_WIDTH-1:0] sh_r_i,
  input  logic                  sh_cf_i,
  input  logic                  sh_zf_i,
  input  logic                  sh_of_i,
  input  logic                  sh_pf_i,
  input  logic                  sh_sf_i,
  output logic                  done_o,
  output logic                  cf_o,
  output logic                  zf_o,
  output logic                  of_o,
  output logic                  pf_o,
  output logic                  sf_o
);

  localparam int W = WORD_WIDTH;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_t                  state, next_state;
  mode_t                   mode_q;
  logic [AW-1:0]           amt_q;
  logic [IW-1:0]           idx;
  logic [WORDS-1:0][W-1:0] word_buf;
  logic [W-2:0]            lowsave;
  logic [W-2:0]            fill;
  logic                    in_fire, out_fire, at_last;
  logic                    cf_q, zf_q, of_q, pf_q, sf_q;

  shift_fill_select #(.W(W), .WORDS(WORDS)) u_fill (
    .mode    (mode_q),
    .words   (word_buf),
    .lowsave (lowsave),
    .idx     (idx),
    .fill    (fill)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // The block only sees real operands during EXEC; elsewhere its inputs rest at zero.
  always_comb begin
    next_state       = state;
    at_last          = (idx == LAST);
    in_fire          = (state == LOAD) && stream.in_valid;
    out_fire         = (state == DRAIN) && stream.out_ready;
    stream.in_ready  = (state == LOAD);
    stream.out_valid = (state == DRAIN);
    stream.out_data  = '0;
    busy_o           = (state != IDLE);
    done_o           = 1'b0;
    sh_op_o          = '0;
    sh_a_o           = '0;
    sh_b_o           = '0;
    sh_c_o           = '0;
    sh_cf_o          = 1'b0;
    case (state)
      IDLE:  if (start_i) next_state = LOAD;
      LOAD:  if (in_fire && at_last) next_state = EXEC;
      EXEC: begin
        sh_op_o = mode_q;
        sh_a_o  = word_buf[idx];
        sh_b_o  = W'(amt_q);
        sh_c_o  = fill;
        sh_cf_o = cf_i;
        if (at_last) next_state = DRAIN;
      end
      DRAIN: begin
        stream.out_data = word_buf[idx];
        if (out_fire && at_last) begin
          done_o     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Words are shifted in place from the bottom up, so each upper neighbour is still
  // unshifted when it supplies fill bits to the word below it.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      mode_q <= MODE_LOGICAL;
      amt_q  <= '0;
      cf_q   <= 1'b0;
      zf_q   <= 1'b0;
      of_q   <= 1'b0;
      pf_q   <= 1'b0;
      sf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          mode_q <= mode_t'(mode_i);
          amt_q  <= amt_i;
          idx    <= '0;
        end
        LOAD: if (in_fire) begin
          word_buf[idx] <= stream.in_data;
          if (idx == '0) lowsave <= stream.in_data[W-2:0];
          idx <= at_last ? '0 : idx + 1'b1;
        end
        EXEC: begin
          word_buf[idx] <= sh_r_i;
          if (idx == '0) begin
            cf_q <= sh_cf_i;
            pf_q <= sh_pf_i;
            zf_q <= sh_zf_i;
          end else begin
            zf_q <= zf_q & sh_zf_i;
          end
          if (at_last) begin
            sf_q <= sh_sf_i;
            of_q <= sh_of_i;
          end
          idx <= at_last ? '0 : idx + 1'b1;
        end
        DRAIN: if (out_fire) idx <= at_last ? '0 : idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign cf_o = cf_q;
  assign zf_o = zf_q;
  assign of_o = of_q;
  assign pf_o = pf_q;
  assign sf_o = sf_q;

endmodule

// File: tb/tb_right_shift_sequencer.sv
// Directed bench for right_shift_sequencer (W=8, WORDS=4) wrapped around a
// behavioural stand-in for the right_shift_block.
module tb_right_shift_sequencer;

  localparam int W = 8;
  localparam int WORDS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [1:0] mode_i;
  logic [2:0] amt_i;
  logic       busy_o;
  logic       cf_i;
  logic [1:0] sh_op;
  logic [7:0] sh_a, sh_b, sh_r;
  logic [6:0] sh_c;
  logic       sh_cf, sh_cf_r, sh_zf, sh_of, sh_pf, sh_sf;
  logic       done_o, cf_o, zf_o, of_o, pf_o, sf_o;
  logic [14:0] cat;

  int total = 0;
  int bad = 0;

  right_shift_sequencer_if #(.W(W)) stream_if ();

  right_shift_sequencer #(.WORD_WIDTH(W), .WORDS(WORDS)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .mode_i  (mode_i),
    .amt_i   (amt_i),
    .busy_o  (busy_o),
    .stream  (stream_if),
    .cf_i    (cf_i),
    .sh_op_o (sh_op),
    .sh_a_o  (sh_a),
    .sh_b_o  (sh_b),
    .sh_c_o  (sh_c),
    .sh_cf_o (sh_cf),
    .sh_r_i  (sh_r),
    .sh_cf_i (sh_cf_r),
    .sh_zf_i (sh_zf),
    .sh_of_i (sh_of),
    .sh_pf_i (sh_pf),
    .sh_sf_i (sh_sf),
    .done_o  (done_o),
    .cf_o    (cf_o),
    .zf_o    (zf_o),
    .of_o    (of_o),
    .pf_o    (pf_o),
    .sf_o    (sf_o)
  );

  always #5 clk = ~clk;

  // Shift block stand-in: fill bits sit above the word, cf is the last bit shifted out.
  always_comb begin
    cat     = {sh_c, sh_a};
    sh_r    = 8'(cat >> sh_b);
    sh_cf_r = (sh_b == 8'd0) ? sh_cf : sh_a[sh_b[2:0] - 3'd1];
    sh_zf   = (sh_r == 8'd0);
    sh_sf   = sh_r[7];
    sh_pf   = ^sh_r;
    sh_of   = sh_a[7] ^ sh_r[7];
  end

  typedef struct {
    logic [1:0]  mode;
    logic [2:0]  amt;
    logic [31:0] operand;
    logic        cfin;
    logic [31:0] result;
    logic        zf, sf, cf, pf, of;
  } vec_t;

  vec_t vecs [12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic [2:0] amt,
                               input logic [31:0] operand, input logic cfin,
                               input bit stall, input bit poke,
                               output logic [31:0] result, output int dones,
                               output int done_beat, output int lat,
                               output int busy_low, output bit timeout);
    int  k, cyc, edges;
    bit  fire, seen;
    result = '0; dones = 0; done_beat = -1; lat = -1; busy_low = 0;
    timeout = 1'b0; cyc = 0; edges = 0; seen = 1'b0;
    mode_i = mode; amt_i = amt; cf_i = cfin; start_i = 1'b1;
    @(posedge clk); #1; edges = 1;
    start_i = poke;
    if (poke) begin
      mode_i = ~mode;
      amt_i  = amt ^ 3'd5;
    end
    k = 0;
    while (k < WORDS && cyc < 300) begin
      if (!busy_o) busy_low++;
      stream_if.in_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      stream_if.in_data  = operand[8*k +: 8];
      fire = stream_if.in_valid && stream_if.in_ready;
      @(posedge clk); #1; edges++; cyc++;
      if (fire) k++;
    end
    if (k < WORDS) timeout = 1'b1;
    stream_if.in_valid = 1'b0;
    k = 0;
    while (k < WORDS && cyc < 300) begin
      if (!busy_o) busy_low++;
      if (stream_if.out_valid && !seen) begin
        seen = 1'b1;
        lat  = edges;
      end
      start_i = poke && (k < WORDS - 1);
      stream_if.out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      fire = stream_if.out_valid && stream_if.out_ready;
      if (fire) result[8*k +: 8] = stream_if.out_data;
      if (done_o) begin
        dones++;
        done_beat = k;
      end
      @(posedge clk); #1; edges++; cyc++;
      if (fire) k++;
    end
    if (k < WORDS) timeout = 1'b1;
    start_i = 1'b0;
    stream_if.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] res;
    int          dones, done_beat, lat, busy_low;
    bit          tmo;

    vecs[0]  = '{2'b00, 3'd1, 32'h80000001, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{2'b01, 3'd3, 32'h80000000, 1'b0, 32'hF0000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{2'b00, 3'd3, 32'h80000000, 1'b0, 32'h10000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{2'b10, 3'd4, 32'h00000001, 1'b0, 32'h10000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{2'b10, 3'd7, 32'h12345678, 1'b0, 32'hF02468AC, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{2'b00, 3'd7, 32'h0000007F, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{2'b00, 3'd0, 32'h12345678, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{2'b01, 3'd5, 32'h7FFFFF00, 1'b0, 32'h03FFFFF8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{2'b11, 3'd3, 32'h80000000, 1'b0, 32'h10000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{2'b01, 3'd1, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{2'b10, 3'd1, 32'h80000001, 1'b0, 32'hC0000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{2'b01, 3'd0, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; start_i = 1'b0; mode_i = 2'b00; amt_i = 3'd0; cf_i = 1'b1;
    stream_if.in_valid = 1'b0; stream_if.in_data = 8'h00; stream_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy_o), 32'd0);
    checkOutput("reset in_ready", 32'(stream_if.in_ready), 32'd0);
    checkOutput("reset out_valid", 32'(stream_if.out_valid), 32'd0);
    checkOutput("reset done", 32'(done_o), 32'd0);
    checkOutput("reset flags", 32'({cf_o, zf_o, of_o, pf_o, sf_o}), 32'd0);
    checkOutput("reset sh bus", 32'({sh_op, sh_a, sh_b, sh_c, sh_cf}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].amt, vecs[i].operand, vecs[i].cfin, 1'b0, 1'b0,
                    res, dones, done_beat, lat, busy_low, tmo);
      checkOutput($sformatf("v%0d timeout", i), 32'(tmo), 32'd0);
      checkOutput($sformatf("v%0d data", i), res, vecs[i].result);
      checkOutput($sformatf("v%0d flags cf/zf/of/pf/sf", i), 32'({cf_o, zf_o, of_o, pf_o, sf_o}),
                  32'({vecs[i].cf, vecs[i].zf, vecs[i].of, vecs[i].pf, vecs[i].sf}));
      checkOutput($sformatf("v%0d done count", i), 32'(dones), 32'd1);
      checkOutput($sformatf("v%0d done beat", i), 32'(done_beat), 32'd3);
      checkOutput($sformatf("v%0d latency", i), 32'(lat), 32'd9);
      checkOutput($sformatf("v%0d busy during job", i), 32'(busy_low), 32'd0);
      checkOutput($sformatf("v%0d idle after", i), 32'(busy_o), 32'd0);
    end

    $display("[TB] stalled source and sink");
    applyStimulus(2'b10, 3'd7, 32'h12345678, 1'b0, 1'b1, 1'b0,
                  res, dones, done_beat, lat, busy_low, tmo);
    checkOutput("stall timeout", 32'(tmo), 32'd0);
    checkOutput("stall data", res, 32'hF02468AC);
    checkOutput("stall flags", 32'({cf_o, zf_o, of_o, pf_o, sf_o}), 32'b10101);
    checkOutput("stall done count", 32'(dones), 32'd1);

    $display("[TB] start pulsed while busy");
    applyStimulus(2'b01, 3'd3, 32'h80000000, 1'b0, 1'b1, 1'b1,
                  res, dones, done_beat, lat, busy_low, tmo);
    checkOutput("poke timeout", 32'(tmo), 32'd0);
    checkOutput("poke data", res, 32'hF0000000);
    checkOutput("poke busy held", 32'(busy_low), 32'd0);
    checkOutput("poke done count", 32'(dones), 32'd1);
    @(posedge clk); #1;
    checkOutput("poke no restart", 32'(busy_o), 32'd0);

    $display("[TB] reset during EXEC");
    mode_i = 2'b01; amt_i = 3'd1; cf_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    stream_if.in_valid = 1'b1;
    for (int k = 0; k < WORDS; k++) begin
      stream_if.in_data = 8'hFF;
      @(posedge clk); #1;
    end
    stream_if.in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("exec busy", 32'(busy_o), 32'd1);
    checkOutput("exec sh_a", 32'(sh_a), 32'h000000FF);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst busy", 32'(busy_o), 32'd0);
    checkOutput("midrst handshake", 32'({stream_if.in_ready, stream_if.out_valid, done_o}), 32'd0);
    checkOutput("midrst out_data", 32'(stream_if.out_data), 32'd0);
    checkOutput("midrst flags", 32'({cf_o, zf_o, of_o, pf_o, sf_o}), 32'd0);
    checkOutput("midrst sh bus", 32'({sh_op, sh_a, sh_b, sh_c, sh_cf}), 32'd0);
    applyStimulus(2'b00, 3'd1, 32'h80000001, 1'b0, 1'b0, 1'b0,
                  res, dones, done_beat, lat, busy_low, tmo);
    checkOutput("fresh timeout", 32'(tmo), 32'd0);
    checkOutput("fresh data", res, 32'h40000000);
    checkOutput("fresh flags", 32'({cf_o, zf_o, of_o, pf_o, sf_o}), 32'b10100);
    checkOutput("fresh latency", 32'(lat), 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
